stream_arb_mux: RTL and testbench
=================================

// Module: stream_arb_mux
// PURPOSE
//  Registered M-input, L-bit stream multiplexer with valid/ready handshakes and
//  selectable arbitration (round-robin, fixed priority, or direct address).
//  Merges requesters such as fetch/load/store channels onto one shared
//  memory/bus port of the multicycle processor. One word per cycle sustained.
// PARAMETERS
//  L  16  bits per data word
//  N  2   bits of channel index / addr (2^N >= M)
//  M  4   number of input channels (2 <= M <= 2^N)
// PORTS
//  clk        in   1    rising-edge clock
//  rst_n      in   1    synchronous reset, active low
//  mode       in   2    00 round-robin, 01 fixed priority (ch0 highest), 10 direct addr, 11 = 10
//  addr       in   N    channel selected in direct mode
//  in_valid   in   M    per-channel valid; bit i = channel i
//  in_ready   out  M    per-channel ready; combinational, one-hot or zero
//  D          in   M*L  packed data, channel i at D[i*L +: L]
//  out_valid  out  1    output register holds a word
//  out_ready  in   1    downstream accepts
//  F          out  L    registered output word
//  grant_idx  out  N    channel index that produced F
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): out_valid=0, F=0, grant_idx=0, rr pointer=0; in_ready=0 while rst_n=0.
//  - load_en = ~out_valid | out_ready (empty, or draining this cycle).
//  - Winner w chosen combinationally among in_valid bits:
//    RR: first valid index scanning ptr, ptr+1, ..., M-1, 0, ..., ptr-1.
//    FIXED: lowest valid index. DIRECT: w=addr iff addr<M and in_valid[addr];
//    addr>=M never grants (no error flag).
//  - in_ready[w]=1 only when load_en and a winner exists; all other bits 0.
//  - Transfer on channel i when in_valid[i]&in_ready[i]; at that edge F<=D[w],
//    grant_idx<=w, out_valid<=1. Latency: input accept -> out_valid next cycle.
//  - Output drain when out_valid&out_ready; if no transfer same edge, out_valid<=0,
//    F and grant_idx hold last value. Simultaneous drain+load: new word, out_valid stays 1 (no bubble).
//  - Stall: out_valid=1 & out_ready=0 -> F, grant_idx, out_valid frozen; in_ready=0.
//  - RR pointer: on transfer in RR mode only, ptr<=(w==M-1)?0:w+1. Unchanged
//    in other modes; mode switches take effect the same cycle, no flush.
//  - in_valid may drop without a transfer; no input stickiness required.
//  - Reset mid-stream: pending F word discarded; no in_ready asserted in reset cycle.
// TESTING
//  1 Reset: rst_n=0 2 cycles with in_valid=4'hF -> out_valid=0, F=0, in_ready=0; release -> ch0 granted first.
//  2 RR, L=16 M=4, in_valid=4'hF, out_ready=1, D={16'h4444,16'h3333,16'h2222,16'h1111} ->
//    F = 1111,2222,3333,4444,1111 on consecutive cycles, grant_idx 0,1,2,3,0, no bubbles.
//  3 FIXED, in_valid=4'b1010 -> ch1 only, F=D[1] every cycle; drop bit1 -> ch3 granted.
//  4 DIRECT, addr=2 with in_valid[2]=1 -> F=D[2]; addr=2 with in_valid[2]=0, or M=3 with addr=3 ->
//    in_ready=0, out_valid falls after drain.
//  5 Backpressure: out_ready=0 for 3 cycles while out_valid=1 -> F/grant_idx frozen,
//    in_ready=0; out_ready=1 -> drain + reload same edge.
//  6 RR wrap/fairness: only ch3 and ch0 valid, ptr=3 -> grants 3,0,3,0; random stress vs scoreboard, no loss/duplication.

Source files
------------

// File: rtl/stream_arb_mux.sv
`default_nettype none
// ============================================================================
//  Module      : stream_arb_mux
//  Description : Registered M-input stream multiplexer with valid/ready
//                handshakes and round-robin / fixed / direct arbitration.
//  Revision    : 1.0  initial release
// ============================================================================
module stream_arb_mux #(
    parameter int L = 16,
    parameter int N = 2,
    parameter int M = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     mode,
    input  logic [N-1:0]   addr,
    input  logic [M-1:0]   in_valid,
    output logic [M-1:0]   in_ready,
    input  logic [M*L-1:0] D,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [L-1:0]   F,
    output logic [N-1:0]   grant_idx
);

    localparam int         c_pad  = 2**N;
    localparam logic [N-1:0] c_last = N'(M-1);

    logic               r_out_valid;
    logic [L-1:0]       r_f;
    logic [N-1:0]       r_grant_idx;
    logic [N-1:0]       r_ptr;

    logic [c_pad-1:0]   w_valid_pad;
    logic               w_found;
    logic [N-1:0]       w_win;
    logic [L-1:0]       w_data;
    logic               w_load_en;
    logic               w_xfer;

    // Winner search; candidates are scanned from the far end so the
    // highest-priority match is the last assignment to stick.
    always_comb begin
        int v_idx;
        v_idx       = 0;
        w_valid_pad = '0;
        w_valid_pad[M-1:0] = in_valid;
        w_found     = 1'b0;
        w_win       = '0;
        case (mode)
            2'b00: begin
                for (int k = M-1; k >= 0; k--) begin
                    v_idx = int'(r_ptr) + k;
                    if (v_idx >= M) v_idx = v_idx - M;
                    if (w_valid_pad[N'(v_idx)]) begin
                        w_found = 1'b1;
                        w_win   = N'(v_idx);
                    end
                end
            end
            2'b01: begin
                for (int i = M-1; i >= 0; i--) begin
                    if (in_valid[i]) begin
                        w_found = 1'b1;
                        w_win   = N'(i);
                    end
                end
            end
            default: begin
                // Padding bits above M-1 are zero, so out-of-range addr never grants.
                if (w_valid_pad[addr]) begin
                    w_found = 1'b1;
                    w_win   = addr;
                end
            end
        endcase
    end

    assign w_load_en = ~r_out_valid | out_ready;
    assign w_xfer    = rst_n & w_load_en & w_found;

    always_comb begin
        w_data   = '0;
        in_ready = '0;
        for (int i = 0; i < M; i++) begin
            if (w_win == N'(i)) begin
                w_data      = D[i*L +: L];
                in_ready[i] = w_xfer;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_f         <= '0;
            r_grant_idx <= '0;
            r_ptr       <= '0;
        end else begin
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_f         <= w_data;
                r_grant_idx <= w_win;
                if (mode == 2'b00) begin
                    r_ptr <= (w_win == c_last) ? '0 : w_win + 1'b1;
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign F         = r_f;
    assign grant_idx = r_grant_idx;

endmodule
`default_nettype wire

// File: tb/tb_stream_arb_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_arb_mux
//  Description : Directed vector table, corner sequences and scoreboard stress.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_stream_arb_mux;

    localparam int L = 16;
    localparam int N = 2;
    localparam int M = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [1:0]     mode;
    logic [N-1:0]   addr;
    logic [M-1:0]   in_valid;
    logic [M-1:0]   in_ready;
    logic [M*L-1:0] D;
    logic           out_valid;
    logic           out_ready;
    logic [L-1:0]   F;
    logic [N-1:0]   grant_idx;

    logic           rst3_n;
    logic [1:0]     mode3;
    logic [N-1:0]   addr3;
    logic [2:0]     in_valid3;
    logic [2:0]     in_ready3;
    logic [3*L-1:0] D3;
    logic           out_valid3;
    logic           out_ready3;
    logic [L-1:0]   F3;
    logic [N-1:0]   grant_idx3;

    always #5 clk = ~clk;

    stream_arb_mux #(.L(L), .N(N), .M(M)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .addr(addr),
        .in_valid(in_valid), .in_ready(in_ready), .D(D),
        .out_valid(out_valid), .out_ready(out_ready),
        .F(F), .grant_idx(grant_idx)
    );

    stream_arb_mux #(.L(L), .N(N), .M(3)) dut3 (
        .clk(clk), .rst_n(rst3_n), .mode(mode3), .addr(addr3),
        .in_valid(in_valid3), .in_ready(in_ready3), .D(D3),
        .out_valid(out_valid3), .out_ready(out_ready3),
        .F(F3), .grant_idx(grant_idx3)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic           rst_n;
        logic [1:0]     mode;
        logic [N-1:0]   addr;
        logic [M-1:0]   inv;
        logic           ordy;
        logic [M-1:0]   e_rdy;
        logic           e_ov;
        logic [L-1:0]   e_f;
        logic [N-1:0]   e_g;
    } vec_t;

    vec_t tbl[$];
    logic [N+L-1:0] sb[$];
    logic [N+L-1:0] exp_word;

    initial begin
        rst_n = 1'b0; mode = 2'b00; addr = '0; in_valid = 4'hF; out_ready = 1'b1;
        D = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        rst3_n = 1'b0; mode3 = 2'b10; addr3 = '0; in_valid3 = '0; out_ready3 = 1'b1;
        D3 = {16'hCCCC, 16'hBBBB, 16'hAAAA};

        //              rst  mode  addr inv    ordy  rdy     ov  F         g
        tbl.push_back('{1'b0, 2'd0, 2'd0, 4'hF,   1'b1, 4'b0000, 1'b0, 16'h0000, 2'd0});
        tbl.push_back('{1'b0, 2'd0, 2'd0, 4'hF,   1'b1, 4'b0000, 1'b0, 16'h0000, 2'd0});
        tbl.push_back('{1'b1, 2'd0, 2'd0, 4'hF,   1'b1, 4'b0001, 1'b1, 16'h1111, 2'd0});
        tbl.push_back('{1'b1, 2'd0, 2'd0, 4'hF,   1'b1, 4'b0010, 1'b1, 16'h2222, 2'd1});
        tbl.push_back('{1'b1, 2'd0, 2'd0, 4'hF,   1'b1, 4'b0100, 1'b1, 16'h3333, 2'd2});
        tbl.push_back('{1'b1, 2'd0, 2'd0, 4'hF,   1'b1, 4'b1000, 1'b1, 16'h4444, 2'd3});
        tbl.push_back('{1'b1, 2'd0, 2'd0, 4'hF,   1'b1, 4'b0001, 1'b1, 16'h1111, 2'd0});
        tbl.push_back('{1'b1, 2'd0, 2'd0, 4'hF,   1'b0, 4'b0000, 1'b1, 16'h1111, 2'd0});
        tbl.push_back('{1'b1, 2'd0, 2'd0, 4'hF,   1'b0, 4'b0000, 1'b1, 16'h1111, 2'd0});
        tbl.push_back('{1'b1, 2'd0, 2'd0, 4'hF,   1'b0, 4'b0000, 1'b1, 16'h1111, 2'd0});
        tbl.push_back('{1'b1, 2'd0, 2'd0, 4'hF,   1'b1, 4'b0010, 1'b1, 16'h2222, 2'd1});
        tbl.push_back('{1'b1, 2'd1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 16'h2222, 2'd1});
        tbl.push_back('{1'b1, 2'd1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 16'h2222, 2'd1});
        tbl.push_back('{1'b1, 2'd1, 2'd0, 4'b1000, 1'b1, 4'b1000, 1'b1, 16'h4444, 2'd3});
        tbl.push_back('{1'b1, 2'd2, 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1, 16'h3333, 2'd2});
        tbl.push_back('{1'b1, 2'd3, 2'd2, 4'b1011, 1'b1, 4'b0000, 1'b0, 16'h3333, 2'd2});
        tbl.push_back('{1'b1, 2'd3, 2'd2, 4'b1011, 1'b1, 4'b0000, 1'b0, 16'h3333, 2'd2});
        tbl.push_back('{1'b1, 2'd0, 2'd0, 4'b0100, 1'b1, 4'b0100, 1'b1, 16'h3333, 2'd2});
        tbl.push_back('{1'b1, 2'd0, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 16'h4444, 2'd3});
        tbl.push_back('{1'b1, 2'd0, 2'd0, 4'b1001, 1'b1, 4'b0001, 1'b1, 16'h1111, 2'd0});
        tbl.push_back('{1'b1, 2'd0, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 16'h4444, 2'd3});
        tbl.push_back('{1'b1, 2'd0, 2'd0, 4'b1001, 1'b1, 4'b0001, 1'b1, 16'h1111, 2'd0});
        tbl.push_back('{1'b1, 2'd0, 2'd0, 4'b0000, 1'b0, 4'b0000, 1'b1, 16'h1111, 2'd0});
        tbl.push_back('{1'b1, 2'd0, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 16'h1111, 2'd0});
        tbl.push_back('{1'b1, 2'd0, 2'd0, 4'hF,   1'b1, 4'b0010, 1'b1, 16'h2222, 2'd1});
        tbl.push_back('{1'b0, 2'd0, 2'd0, 4'hF,   1'b1, 4'b0000, 1'b0, 16'h0000, 2'd0});
        tbl.push_back('{1'b1, 2'd0, 2'd0, 4'hF,   1'b0, 4'b0001, 1'b1, 16'h1111, 2'd0});

        for (int v = 0; v < tbl.size(); v++) begin
            @(negedge clk);
            rst_n = tbl[v].rst_n; mode = tbl[v].mode; addr = tbl[v].addr;
            in_valid = tbl[v].inv; out_ready = tbl[v].ordy;
            #1;
            chk($sformatf("v%0d in_ready", v), 32'(in_ready), 32'(tbl[v].e_rdy));
            @(posedge clk); #1;
            chk($sformatf("v%0d out_valid", v), 32'(out_valid), 32'(tbl[v].e_ov));
            chk($sformatf("v%0d F", v), 32'(F), 32'(tbl[v].e_f));
            chk($sformatf("v%0d grant_idx", v), 32'(grant_idx), 32'(tbl[v].e_g));
        end

        // Three-channel instance: addr beyond the last channel must never grant.
        @(negedge clk);
        rst3_n = 1'b1; mode3 = 2'b10; addr3 = 2'd2; in_valid3 = 3'b111; out_ready3 = 1'b1;
        #1 chk("m3 addr2 in_ready", 32'(in_ready3), 32'h4);
        @(posedge clk); #1;
        chk("m3 addr2 out_valid", 32'(out_valid3), 32'h1);
        chk("m3 addr2 F", 32'(F3), 32'hCCCC);
        chk("m3 addr2 grant_idx", 32'(grant_idx3), 32'h2);
        @(negedge clk);
        addr3 = 2'd3;
        #1 chk("m3 addr3 in_ready", 32'(in_ready3), 32'h0);
        @(posedge clk); #1;
        chk("m3 addr3 out_valid", 32'(out_valid3), 32'h0);
        chk("m3 addr3 F hold", 32'(F3), 32'hCCCC);

        // Random stress against a one-deep scoreboard, starting from reset.
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        for (int c = 0; c < 304; c++) begin
            @(negedge clk);
            rst_n = 1'b1;
            mode = 2'($urandom_range(0, 3));
            addr = 2'($urandom_range(0, 3));
            in_valid = (c < 300) ? 4'($urandom_range(0, 15)) : 4'b0000;
            out_ready = (c < 300) ? ($urandom_range(0, 3) != 0) : 1'b1;
            D = {$urandom(), $urandom()};
            #1;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL sb_drain: got %0h expected no word", {grant_idx, F});
                end else begin
                    exp_word = sb.pop_front();
                    chk($sformatf("sb_drain c%0d", c), 32'({grant_idx, F}), 32'(exp_word));
                end
            end
            chk($sformatf("rdy_onehot0 c%0d", c), 32'($onehot0(in_ready)), 32'h1);
            chk($sformatf("rdy_subset c%0d", c), 32'(in_ready & ~in_valid), 32'h0);
            for (int i = 0; i < M; i++) begin
                if (in_ready[i] && in_valid[i]) sb.push_back({N'(i), D[i*L +: L]});
            end
            @(posedge clk);
        end
        #1;
        chk("sb_final_empty", 32'(sb.size()), 32'h0);
        chk("final out_valid", 32'(out_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
